// File: rtl/ttt_move_sequencer.sv
// Player-side tic-tac-toe move sequencer: validates keypad picks, issues moves over valid/ready,
// shadows the board and detects win/draw. Optional TURN_TIMEOUT_EN adds a per-turn forfeit timer.
module ttt_move_sequencer #(
  parameter logic        FIRST_PLAYER   = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_pos,
  input  logic       move_ready,
  output logic       move_valid,
  output logic       player,
  output logic [3:0] position,
  output logic       illegal,
  output logic [8:0] occupied,
  output logic [8:0] owner,
  output logic [3:0] turn_count,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {S_WAIT_KEY, S_ISSUE, S_CHECK, S_DONE} state_t;

  state_t     r_state,      w_state_nxt;
  logic       r_player,     w_player_nxt;
  logic [3:0] r_position,   w_position_nxt;
  logic       r_illegal,    w_illegal_nxt;
  logic [8:0] r_occupied,   w_occupied_nxt;
  logic [8:0] r_owner,      w_owner_nxt;
  logic [3:0] r_turn_count, w_turn_count_nxt;
  logic       r_game_over,  w_game_over_nxt;
  logic [1:0] r_winner,     w_winner_nxt;

  logic [15:0] w_occ_ext;
  logic        w_key_legal;
  logic        w_win_p1;
  logic        w_win_p2;
  logic        w_timeout;

  function automatic logic line_owned(input logic [8:0] occ, input logic [8:0] own,
                                      input logic who, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return occ[a] && occ[b] && occ[c] && (own[a] == who) && (own[b] == who) && (own[c] == who);
  endfunction

  function automatic logic has_line(input logic [8:0] occ, input logic [8:0] own, input logic who);
    return line_owned(occ, own, who, 4'd0, 4'd1, 4'd2) || line_owned(occ, own, who, 4'd3, 4'd4, 4'd5) ||
           line_owned(occ, own, who, 4'd6, 4'd7, 4'd8) || line_owned(occ, own, who, 4'd0, 4'd3, 4'd6) ||
           line_owned(occ, own, who, 4'd1, 4'd4, 4'd7) || line_owned(occ, own, who, 4'd2, 4'd5, 4'd8) ||
           line_owned(occ, own, who, 4'd0, 4'd4, 4'd8) || line_owned(occ, own, who, 4'd2, 4'd4, 4'd6);
  endfunction

  // Cells 9..15 read as permanently occupied, so one lookup covers range and occupancy.
  assign w_occ_ext   = {7'h7f, r_occupied};
  assign w_key_legal = key_valid && !w_occ_ext[key_pos];
  assign w_win_p1    = has_line(r_occupied, r_owner, 1'b0);
  assign w_win_p2    = has_line(r_occupied, r_owner, 1'b1);

`ifdef TURN_TIMEOUT_EN
  logic [31:0] r_timer;

  // Held at zero outside WAIT_KEY, so every entry to WAIT_KEY starts a fresh count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      r_timer <= '0;
    else if (r_state != S_WAIT_KEY) r_timer <= '0;
    else                            r_timer <= r_timer + 32'd1;
  end

  assign w_timeout = (r_state == S_WAIT_KEY) && (r_timer == TIMEOUT_CYCLES - 1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_nxt      = r_state;
    w_player_nxt     = r_player;
    w_position_nxt   = r_position;
    w_illegal_nxt    = 1'b0;
    w_occupied_nxt   = r_occupied;
    w_owner_nxt      = r_owner;
    w_turn_count_nxt = r_turn_count;
    w_game_over_nxt  = r_game_over;
    w_winner_nxt     = r_winner;
    unique case (r_state)
      S_WAIT_KEY: begin
        if (w_key_legal) begin
          w_position_nxt = key_pos;
          w_state_nxt    = S_ISSUE;
        end else begin
          if (key_valid) w_illegal_nxt = 1'b1;
          if (w_timeout) begin
            w_winner_nxt    = r_player ? 2'b01 : 2'b10;
            w_game_over_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (move_ready) begin
          w_occupied_nxt[r_position] = 1'b1;
          w_owner_nxt[r_position]    = r_player;
          w_turn_count_nxt           = r_turn_count + 4'd1;
          w_state_nxt                = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_win_p1 || w_win_p2 || (r_turn_count == 4'd9)) begin
          w_winner_nxt    = w_win_p1 ? 2'b01 : (w_win_p2 ? 2'b10 : 2'b11);
          w_game_over_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else begin
          w_player_nxt = ~r_player;
          w_state_nxt  = S_WAIT_KEY;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_WAIT_KEY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_WAIT_KEY;
      r_player     <= FIRST_PLAYER;
      r_position   <= '0;
      r_illegal    <= 1'b0;
      r_occupied   <= '0;
      r_owner      <= '0;
      r_turn_count <= '0;
      r_game_over  <= 1'b0;
      r_winner     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_player     <= w_player_nxt;
      r_position   <= w_position_nxt;
      r_illegal    <= w_illegal_nxt;
      r_occupied   <= w_occupied_nxt;
      r_owner      <= w_owner_nxt;
      r_turn_count <= w_turn_count_nxt;
      r_game_over  <= w_game_over_nxt;
      r_winner     <= w_winner_nxt;
    end
  end

  assign move_valid = (r_state == S_ISSUE);
  assign player     = r_player;
  assign position   = r_position;
  assign illegal    = r_illegal;
  assign occupied   = r_occupied;
  assign owner      = r_owner;
  assign turn_count = r_turn_count;
  assign game_over  = r_game_over;
  assign winner     = r_winner;

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Scoreboard bench for ttt_move_sequencer: expected moves are queued as keys are driven and
// matched when the board handshake completes; game-level results are checked against constants.
module tb_ttt_move_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_pos;
  logic       move_ready;
  logic       move_valid;
  logic       player;
  logic [3:0] position;
  logic       illegal;
  logic [8:0] occupied;
  logic [8:0] owner;
  logic [3:0] turn_count;
  logic       game_over;
  logic [1:0] winner;

  ttt_move_sequencer #(
    .FIRST_PLAYER  (1'b0),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_pos   (key_pos),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .player    (player),
    .position  (position),
    .illegal   (illegal),
    .occupied  (occupied),
    .owner     (owner),
    .turn_count(turn_count),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  int unsigned n_checks  = 0;
  int unsigned n_errors  = 0;
  int unsigned n_illegal = 0;
  logic [4:0]  sb_q[$];
  logic        exp_player;
  int unsigned ill0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change at posedge+1, so the falling edge sees what the next rising edge will sample.
  always @(negedge clk) begin
    if (illegal === 1'b1) n_illegal++;
    if (move_valid === 1'b1 && move_ready === 1'b1) begin
      if (sb_q.size() == 0) check("sb_extra_move", sb_q.size(), 1);
      else                  check("sb_move", {player, position}, sb_q.pop_front());
    end
  end

  task automatic do_reset();
    reset      = 1'b1;
    key_valid  = 1'b0;
    key_pos    = 4'd0;
    move_ready = 1'b1;
    sb_q.delete();
    exp_player = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] pos);
    @(posedge clk); #1;
    key_valid = 1'b1;
    key_pos   = pos;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic play(input logic [3:0] pos, input bit legal);
    if (legal) sb_q.push_back({exp_player, pos});
    press(pos);
    if (legal) check("move_latency", move_valid, 1);
    repeat (2) @(posedge clk);
    #1;
    if (legal) exp_player = ~exp_player;
  endtask

  task automatic play_seq(input int unsigned n, input logic [35:0] cells);
    for (int unsigned i = 0; i < n; i++) play(cells[(n - 1 - i) * 4 +: 4], 1'b1);
  endtask

  initial begin
    do_reset();
    check("rst_move_valid", move_valid, 0);
    check("rst_player", player, 0);
    check("rst_position", position, 0);
    check("rst_illegal", illegal, 0);
    check("rst_board", {occupied, owner}, 0);
    check("rst_result", {turn_count, game_over, winner}, 0);

    // First legal move
    play(4'd4, 1'b1);
    check("t1_occupied", occupied, 9'h010);
    check("t1_owner", owner, 9'h000);
    check("t1_turns", turn_count, 1);
    check("t1_player", player, 1);

    // Occupied and out-of-range picks
    ill0 = n_illegal;
    play(4'd4, 1'b0);
    check("t2_ill_occ", n_illegal - ill0, 1);
    check("t2_occupied", occupied, 9'h010);
    check("t2_player", player, 1);
    play(4'd12, 1'b0);
    check("t2_ill_range", n_illegal - ill0, 2);
    check("t2_turns", turn_count, 1);

    // Back-pressure with ignored keys
    move_ready = 1'b0;
    sb_q.push_back({exp_player, 4'd0});
    press(4'd0);
    check("t3_latency", move_valid, 1);
    ill0 = n_illegal;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin key_valid = 1'b1; key_pos = 4'd8; end
      else key_valid = 1'b0;
      @(posedge clk); #1;
      check("t3_hold_valid", move_valid, 1);
      check("t3_hold_player", player, 1);
      check("t3_hold_pos", position, 0);
    end
    move_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_player = 1'b0;
    check("t3_occupied", occupied, 9'h011);
    check("t3_owner", owner, 9'h001);
    check("t3_turns", turn_count, 2);
    check("t3_player", player, 0);
    check("t3_no_illegal", n_illegal - ill0, 0);

    // Row win for P1, then lockout
    do_reset();
    play_seq(5, 36'h03142);
    check("t4_winner", winner, 2'b01);
    check("t4_game_over", game_over, 1);
    check("t4_turns", turn_count, 5);
    ill0 = n_illegal;
    press(4'd7);
    repeat (3) @(posedge clk);
    #1;
    check("t4_lock_valid", move_valid, 0);
    check("t4_lock_illegal", n_illegal - ill0, 0);
    check("t4_lock_board", {occupied, owner}, {9'h01F, 9'h018});
    check("t4_lock_winner", winner, 2'b01);

    // Draw
    do_reset();
    play_seq(9, 36'h012435768);
    check("t5_draw_winner", winner, 2'b11);
    check("t5_draw_turns", turn_count, 9);
    check("t5_draw_board", {occupied, owner}, {9'h1FF, 9'h072});
    check("t5_draw_over", game_over, 1);

    // Ninth move completes a diagonal: win beats draw
    do_reset();
    play_seq(9, 36'h402537186);
    check("t5_win9_winner", winner, 2'b01);
    check("t5_win9_turns", turn_count, 9);

    // Asynchronous reset during ISSUE
    do_reset();
    play(4'd4, 1'b1);
    move_ready = 1'b0;
    sb_q.push_back({exp_player, 4'd5});
    press(4'd5);
    check("t6_issue_valid", move_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", move_valid, 0);
    check("t6_async_player", player, 0);
    check("t6_async_pos", position, 0);
    check("t6_async_board", {occupied, owner}, 0);
    check("t6_async_result", {turn_count, game_over, winner}, 0);
    do_reset();

`ifdef TURN_TIMEOUT_EN
    for (int i = 0; i < 20 && game_over !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    check("t6_timeout_over", game_over, 1);
    check("t6_timeout_winner", winner, 2'b10);
`else
    repeat (20) @(posedge clk);
    #1;
    check("t6_idle_over", game_over, 0);
    check("t6_idle_winner", winner, 2'b00);
`endif

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
